// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage: one multiplier bit per cycle,
// terminating early once the remaining multiplier bits are all zero.
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  // Handshake: the pipeline holds start_i with a_i/b_i while stall_o is high.
  // Operands are taken on the accept edge (IDLE, start_i=1, flush_i=0).
  // done_o is a one-cycle pulse with result_o valid and stall_o low, so the
  // stalled instruction advances at the end of the done cycle.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            acc    <= '0;
            mcand  <= a_i;
            mplier <= b_i;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            state <= IDLE;
          end else if (mplier == '0) begin
            result_o <= acc;
            done_o   <= 1'b1;
            state    <= DONE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state == RUN);
  // Stall asserts in the accept cycle itself so IF/ID/EX freeze immediately.
  assign stall_o = !rst_i && (((state == IDLE) && start_i && !flush_i) || (state == RUN));

  // Every shift retires one multiplier bit, so WIDTH shifts always empty it.
  count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    !((count == CNT_W'(WIDTH)) && (mplier != '0)));

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: vector table of single multiplies plus
// hand-written flush, flush-in-done and asynchronous reset sequences.
module tb_mul_sequencer;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         flush_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         stall_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         busy_o;

  int compared = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_result;
    int           exp_cycle;
  } vec_t;

  vec_t vecs[9];

  mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called in cycle 0 (state IDLE, just after a falling edge); returns in the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int exp_cyc, input string name);
    int c;
    bit fin;
    logic [W-1:0] want;
    exp_q.push_back(exp);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    flush_i = 1'b0;
    #1;
    check({name, " c0 stall"}, W'(stall_o), W'(1));
    check({name, " c0 busy"}, W'(busy_o), W'(0));
    c = 0;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk_i);
      c++;
      @(negedge clk_i);
      #1;
      check($sformatf("%s c%0d stall", name, c), W'(stall_o), W'(c < exp_cyc));
      check($sformatf("%s c%0d busy", name, c), W'(busy_o), W'(c < exp_cyc));
      check($sformatf("%s c%0d done", name, c), W'(done_o), W'(c == exp_cyc));
      // operands must be ignored after accept
      if (c == 1) begin
        a_i = ~a;
        b_i = b ^ 32'h5a5a_5a5a;
      end
      if (done_o || c >= exp_cyc || c >= 60) fin = 1'b1;
    end
    want = exp_q.pop_front();
    check({name, " result"}, result_o, want);
    start_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd7,         32'd6,         32'd42,        5};
    vecs[1] = '{32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 2};
    vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 4};
    vecs[4] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 34};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34};
    vecs[6] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 19};
    vecs[7] = '{32'd12345,     32'd1,         32'd12345,     3};
    vecs[8] = '{32'hDEAD_BEEF, 32'h0000_0002, 32'hBD5B_7DDE, 4};

    // reset with start already held high
    rst_i = 1'b1;
    start_i = 1'b1;
    flush_i = 1'b0;
    a_i = 32'd7;
    b_i = 32'd6;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset stall", W'(stall_o), W'(0));
    check("reset busy", W'(busy_o), W'(0));
    check("reset done", W'(done_o), W'(0));
    check("reset result", result_o, W'(0));

    for (int i = 0; i < 9; i++) begin
      @(negedge clk_i);
      if (i == 0) rst_i = 1'b0;
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_result, vecs[i].exp_cycle, $sformatf("vec%0d", i));
    end

    repeat (2) @(negedge clk_i);
    #1;
    check("hold result", result_o, 32'hBD5B_7DDE);
    check("hold done", W'(done_o), W'(0));

    // flush in RUN: no done pulse, result kept, next op runs normally
    @(negedge clk_i);
    a_i = 32'd5;
    b_i = 32'h0000_00F0;
    start_i = 1'b1;
    #1;
    check("flush c0 stall", W'(stall_o), W'(1));
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      check($sformatf("flush c%0d busy", c), W'(busy_o), W'(1));
      check($sformatf("flush c%0d done", c), W'(done_o), W'(0));
    end
    flush_i = 1'b1;
    start_i = 1'b0;
    #1;
    check("flush c3 stall", W'(stall_o), W'(1));
    @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    check("flush idle busy", W'(busy_o), W'(0));
    check("flush idle done", W'(done_o), W'(0));
    check("flush idle stall", W'(stall_o), W'(0));
    check("flush kept result", result_o, 32'hBD5B_7DDE);
    run_op(32'd3, 32'd4, 32'd12, 5, "post_flush");

    // flush in DONE still pulses done; flush in IDLE blocks accept
    @(negedge clk_i);
    a_i = 32'd6;
    b_i = 32'd1;
    start_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    flush_i = 1'b1;
    #1;
    check("done_flush done", W'(done_o), W'(1));
    check("done_flush result", result_o, 32'd6);
    check("done_flush stall", W'(stall_o), W'(0));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      #1;
      check($sformatf("idle_flush%0d stall", c), W'(stall_o), W'(0));
      check($sformatf("idle_flush%0d busy", c), W'(busy_o), W'(0));
      check($sformatf("idle_flush%0d done", c), W'(done_o), W'(0));
    end
    flush_i = 1'b0;
    start_i = 1'b0;

    // asynchronous reset in cycle 10 of a long multiply
    @(negedge clk_i);
    a_i = 32'd1;
    b_i = 32'h8000_0000;
    start_i = 1'b1;
    repeat (10) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    #1;
    check("pre_reset busy", W'(busy_o), W'(1));
    a_i = 32'd2;
    b_i = 32'd2;
    #1;
    rst_i = 1'b1;
    #1;
    check("async reset stall", W'(stall_o), W'(0));
    check("async reset busy", W'(busy_o), W'(0));
    check("async reset done", W'(done_o), W'(0));
    check("async reset result", result_o, W'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    run_op(32'd2, 32'd2, 32'd4, 4, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Iterative shift-add multiplier controller for the EX stage. It runs the MUL ALU operation over multiple cycles instead of through a single-cycle multiplier. The pipeline issues start_i when the decoded ALU control selects MUL. The block holds stall_o high to freeze IF/ID/EX until the product is ready, then presents result_o to the EX/MEM mux for one done_o cycle.

Parameters:
WIDTH, 32, operand and result width in bits.
CNT_W, 6, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  EX stage holds a valid MUL instruction
flush_i  input  1  pipeline flush; aborts an operation in progress
a_i  input  WIDTH  multiplicand (rs data)
b_i  input  WIDTH  multiplier (rt data)
stall_o  output  1  freeze IF/ID/EX while the multiply is pending
done_o  output  1  one-cycle pulse: result_o valid for the EX instruction
result_o  output  WIDTH  low WIDTH bits of a_i*b_i
busy_o  output  1  state is RUN

Behaviour:
- Reset (rst_i=1, asynchronous):
  - state=IDLE; internal acc, mcand, mplier and count all 0.
  - result_o=0, done_o=0, busy_o=0.
  - stall_o forced to 0 while rst_i=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1 and flush_i=0, accept: acc<=0, mcand<=a_i, mplier<=b_i, count<=0, then go to RUN. The accept edge is cycle 0.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If flush_i=1, go to IDLE. No done_o; result_o unchanged.
  - Else if mplier==0, go to DONE and latch result_o<=acc.
  - Else: if mplier[0]=1, acc<=acc+mcand (mod 2^WIDTH). Then mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1, and stay in RUN.
- DONE:
  - done_o=1 for exactly this cycle; next state is IDLE unconditionally.
  - start_i is ignored in DONE. The stalled instruction advances at the end of this cycle, so the next MUL is seen in IDLE.
- stall_o is combinational: (state==IDLE && start_i && !flush_i) || state==RUN. It is 0 in DONE.
- busy_o = (state==RUN). done_o = (state==DONE), registered.
- Latency (early termination on zero multiplier):
  - Let k = index of the most significant set bit of b_i, plus 1 (k=0 when b_i=0).
  - done_o is high in cycle k+2 after the accept edge.
  - Worst case, with b_i[WIDTH-1]=1, is WIDTH+2.
  - count never exceeds WIDTH. count==WIDTH with mplier≠0 is unreachable; assert it in simulation.
- Arithmetic:
  - Result is the low WIDTH bits of the product, which are identical for signed and unsigned two's-complement operands.
  - No overflow or hi output.
  - a_i and b_i are sampled only at accept; changes afterwards are ignored.
- result_o holds its value until the next DONE. It is cleared only by reset.
- Flush in DONE has no effect: done_o still pulses, and the pipeline discards the result.
- Reset asserted mid-RUN returns to IDLE immediately with all outputs 0. After reset deasserts, a held start_i starts a fresh operation.

Test Plan:
- Reset, then a_i=7, b_i=6, start_i held high:
  - stall_o=1 from cycle 0 through cycle 4.
  - done_o=1 in cycle 5 with result_o=42; stall_o=0 in that cycle.
- a_i=0x1234, b_i=0: done_o in cycle 2, result_o=0. Separately, a_i=0, b_i=0xFFFFFFFF: done_o in cycle 34, result_o=0.
- a_i=0xFFFFFFFF, b_i=3: done_o in cycle 4, result_o=0xFFFFFFFD.
- a_i=1, b_i=0x80000000: done_o in cycle 34, result_o=0x80000000; busy_o high for cycles 1–33.
- Flush: a_i=5, b_i=0xF0 started, flush_i=1 in cycle 3:
  - state returns to IDLE next cycle; no done_o pulse; result_o keeps its previous value.
  - start_i=1 the following cycle with a_i=3, b_i=4 gives done_o in cycle 5 of that operation with result_o=12.
- Reset mid-operation: rst_i pulsed asynchronously (between clock edges) in cycle 10 of a 0x80000000 multiply:
  - all outputs go to 0 immediately.
  - after release with start_i=1, a_i=2, b_i=2, the new operation completes with result_o=4.
